// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizes for the two-requester (fetch / data) RAM port arbiter.
package mem_port_arbiter_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {SEL_I = 1'b0, SEL_D = 1'b1} rsp_sel_e;
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;
endpackage

// File: rtl/mem_port_prio.sv
// Combinational D-over-I priority picker with a streak counter that forces a
// pending fetch through after MAX_D_STREAK consecutive data grants.
module mem_port_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;
    logic             i_forced;

    assign i_forced = i_req && (streak_q == STREAK_MAX);

    always_comb begin
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        streak_d = streak_q;
        if (!reset) begin
            if (d_req && !i_forced) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
        // The streak only counts data grants that actually held a fetch back.
        if (grant_i || !i_req) begin
            streak_d = '0;
        end else if (grant_d && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and data (D)
// ports with an OBI-style req/gnt/rvalid handshake, one access per cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [BE_W-1:0]   d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic [BE_W-1:0]   ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic     grant_i;
    logic     grant_d;
    logic     any_grant;
    state_e   state_q, state_d;
    rsp_sel_e rsp_sel_q, rsp_sel_d;
    logic     rsp_wr_q, rsp_wr_d;
    logic     rsp_valid;

    mem_port_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant_i(grant_i),
        .grant_d(grant_d)
    );

    assign any_grant = grant_i | grant_d;
    assign i_gnt     = grant_i;
    assign d_gnt     = grant_d;

    assign ram_en    = any_grant;
    assign ram_we    = grant_d ? d_we : '0;
    assign ram_addr  = grant_d ? d_addr : (grant_i ? i_addr : '0);
    assign ram_wdata = any_grant ? d_wdata : '0;

    always_comb begin
        state_d   = state_q;
        rsp_sel_d = rsp_sel_q;
        rsp_wr_d  = rsp_wr_q;
        case (state_q)
            IDLE:    state_d = any_grant ? RESP : IDLE;
            RESP:    state_d = any_grant ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
        if (any_grant) begin
            rsp_sel_d = grant_d ? SEL_D : SEL_I;
            rsp_wr_d  = grant_d & (|d_we);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rsp_sel_q <= SEL_I;
            rsp_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_sel_q <= rsp_sel_d;
            rsp_wr_q  <= rsp_wr_d;
        end
    end

    // A response is pending in exactly the cycle after a grant; write responses carry no data.
    assign rsp_valid = (state_q == RESP);
    assign i_rvalid  = rsp_valid && (rsp_sel_q == SEL_I);
    assign d_rvalid  = rsp_valid && (rsp_sel_q == SEL_D);
    assign i_rdata   = i_rvalid ? ram_rdata : '0;
    assign d_rdata   = (d_rvalid && !rsp_wr_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural byte-enabled RAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 0;
    endtask

    task automatic test_reset();
        reset = 1; i_req = 1; d_req = 1; i_addr = 8'h01; d_addr = 8'h02;
        tick(); tick();
        @(negedge clk);
        n_chk++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_i_gnt: got %b want 0", i_gnt); end
        n_chk++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
        n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        n_chk++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
        n_chk++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", i_rdata, d_rdata); end
        n_chk++; if (ram_addr !== 8'h0 || ram_wdata !== 32'h0 || ram_we !== 4'h0) begin n_fail++; $display("FAIL reset_ram_bus: got %h %h %h want 0", ram_addr, ram_wdata, ram_we); end
        idle_inputs();
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_i_read();
        preload(8'h05, 32'hDEADBEEF);
        i_req = 1; i_addr = 8'h05;
        @(negedge clk);
        n_chk++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL iread_gnt: got i=%b d=%b want i=1 d=0", i_gnt, d_gnt); end
        n_chk++; if (ram_en !== 1'b1 || ram_addr !== 8'h05 || ram_we !== 4'h0) begin n_fail++; $display("FAIL iread_ram: got en=%b addr=%h we=%h want 1 05 0", ram_en, ram_addr, ram_we); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL iread_rvalid: got i=%b d=%b want i=1 d=0", i_rvalid, d_rvalid); end
        n_chk++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iread_rdata: got %h want deadbeef", i_rdata); end
        tick();
        @(negedge clk);
        n_chk++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL iread_rvalid_drop: got %b want 0", i_rvalid); end
        tick();
    endtask

    task automatic test_simultaneous();
        preload(8'h02, 32'h22222222);
        preload(8'h07, 32'h77777777);
        i_req = 1; i_addr = 8'h07; d_req = 1; d_addr = 8'h02;
        @(negedge clk);
        n_chk++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL simul_c0_gnt: got i=%b d=%b want i=0 d=1", i_gnt, d_gnt); end
        n_chk++; if (ram_addr !== 8'h02) begin n_fail++; $display("FAIL simul_c0_addr: got %h want 02", ram_addr); end
        tick();
        d_req = 0;
        @(negedge clk);
        n_chk++; if (i_gnt !== 1'b1 || ram_addr !== 8'h07) begin n_fail++; $display("FAIL simul_c1_gnt: got i=%b addr=%h want 1 07", i_gnt, ram_addr); end
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h22222222) begin n_fail++; $display("FAIL simul_c1_drsp: got %b %h want 1 22222222", d_rvalid, d_rdata); end
        tick();
        i_req = 0;
        @(negedge clk);
        n_chk++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h77777777 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL simul_c2_irsp: got %b %h d=%b want 1 77777777 d=0", i_rvalid, i_rdata, d_rvalid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        preload(8'h10, 32'hAAAAAAAA);
        d_req = 1; d_we = 4'b0011; d_addr = 8'h10; d_wdata = 32'h12345678;
        @(negedge clk);
        n_chk++; if (d_gnt !== 1'b1 || ram_we !== 4'b0011 || ram_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_c0: got gnt=%b we=%b wdata=%h want 1 0011 12345678", d_gnt, ram_we, ram_wdata); end
        tick();
        d_we = 4'b0000; d_wdata = 32'h0;
        @(negedge clk);
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_c1_rsp: got %b %h want 1 00000000", d_rvalid, d_rdata); end
        n_chk++; if (d_gnt !== 1'b1 || ram_we !== 4'b0000) begin n_fail++; $display("FAIL rd_c1_gnt: got gnt=%b we=%b want 1 0000", d_gnt, ram_we); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hAAAA5678) begin n_fail++; $display("FAIL raw_c2_rdata: got %b %h want 1 aaaa5678", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_d [6];
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        i_req = 1; i_addr = 8'h20; d_req = 1; d_addr = 8'h30;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (d_gnt !== exp_d[k] || i_gnt !== !exp_d[k]) begin
                n_fail++; $display("FAIL starve_cycle%0d: got i=%b d=%b want i=%b d=%b", k, i_gnt, d_gnt, !exp_d[k], exp_d[k]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals = '{32'h0000A000, 32'h1111B111, 32'h2222C222, 32'h3333D333};
        for (int k = 0; k < 4; k++) preload(8'(k), vals[k]);
        i_req = 1;
        for (int k = 0; k < 5; k++) begin
            i_addr = 8'(k);
            if (k == 4) i_req = 0;
            @(negedge clk);
            if (k < 4) begin
                n_chk++; if (i_gnt !== 1'b1 || ram_addr !== 8'(k)) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b addr=%h want 1 %h", k, i_gnt, ram_addr, 8'(k)); end
            end
            if (k > 0) begin
                n_chk++; if (i_rvalid !== 1'b1 || i_rdata !== vals[k-1]) begin n_fail++; $display("FAIL b2b_rsp%0d: got %b %h want 1 %h", k-1, i_rvalid, i_rdata, vals[k-1]); end
            end
            tick();
        end
        @(negedge clk);
        n_chk++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", i_rvalid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        preload(8'h44, 32'h44444444);
        i_req = 1; i_addr = 8'h50; d_req = 1; d_addr = 8'h44;
        tick();                                   // D granted, streak -> 1
        @(negedge clk);
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_c0_gnt: got %b want 1", d_gnt); end
        tick();                                   // D granted, streak -> 2
        reset = 1;
        @(negedge clk);
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h44444444) begin n_fail++; $display("FAIL rmid_c1_rsp: got %b %h want 1 44444444", d_rvalid, d_rdata); end
        n_chk++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_en !== 1'b0) begin n_fail++; $display("FAIL rmid_c1_gnt: got i=%b d=%b en=%b want 000", i_gnt, d_gnt, ram_en); end
        tick();
        reset = 0;
        idle_inputs();
        @(negedge clk);
        n_chk++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_c2_rsp: got %b %b %h %h want 0 0 0 0", d_rvalid, i_rvalid, d_rdata, i_rdata); end
        n_chk++; if (ram_en !== 1'b0 || ram_we !== 4'h0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rmid_c2_ram: got %b %h %h %h want 0", ram_en, ram_we, ram_addr, ram_wdata); end
        n_chk++; if (dut.u_prio.streak_q !== '0) begin n_fail++; $display("FAIL rmid_c2_streak: got %0d want 0", dut.u_prio.streak_q); end
        tick();
        d_req = 1; d_addr = 8'h44;
        @(negedge clk);
        n_chk++; if (d_gnt !== 1'b1 || ram_addr !== 8'h44) begin n_fail++; $display("FAIL rmid_c3_gnt: got %b %h want 1 44", d_gnt, ram_addr); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h44444444) begin n_fail++; $display("FAIL rmid_c4_rsp: got %b %h want 1 44444444", d_rvalid, d_rdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pre_we = 0; pre_addr = 0; pre_data = 0;
        idle_inputs();
        reset = 1;
        #1;
        test_reset();
        test_i_read();
        test_simultaneous();
        test_write_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous block RAM between two requesters: the instruction-fetch port (I) and the MEM-stage data port (D).
- Uses an OBI-style handshake: req, then gnt, then rvalid exactly one cycle after gnt.
- D has priority because the MEM stage holds the older instruction. A streak counter keeps fetch from starving.
- Sits between FETCH/MEM and the RAM instance and replaces the separate direct RAM/ROM hookups.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- MAX_D_STREAK, 3, maximum consecutive D grants while I is pending before I is forced through (legal range ≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request issued to RAM this cycle (combinational)
- i_rvalid  out  1  fetch read data valid (registered)
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  DATA_W/8  byte write enables; 0 means read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request issued this cycle (combinational)
- d_rvalid  out  1  data response valid (registered)
- d_rdata  out  DATA_W  load data; 0 on write responses
- ram_en  out  1  RAM enable
- ram_we  out  DATA_W/8  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high; all state is updated on posedge clk.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt high in the same cycle.
  - It may change its payload, or present its next request, in the cycle after gnt.
  - rvalid pulses exactly one cycle after gnt.
  - At most one grant is issued per cycle. Back-to-back grants give one access per cycle at full throughput.
- Arbitration (combinational from the req inputs and the streak counter):
  - Neither req: no grant; ram_en=0, ram_we=0.
  - Only one req: that requester is granted.
  - Both req: D is granted, unless streak==MAX_D_STREAK, in which case I is granted.
- RAM drive in a grant cycle:
  - ram_en=1; ram_addr comes from the winner.
  - ram_we=d_we only when D wins; otherwise 0.
  - ram_wdata=d_wdata.
  - With no grant, ram_addr and ram_wdata hold 0.
- Response register:
  - On the clock edge after a grant, rsp_sel (I/D), rsp_valid and rsp_wr (=|d_we) are captured.
  - i_rvalid = rsp_valid & sel==I; d_rvalid = rsp_valid & sel==D.
  - i_rdata = ram_rdata when i_rvalid, else 0.
  - d_rdata = ram_rdata when d_rvalid & !rsp_wr, else 0.
- Streak counter (width clog2(MAX_D_STREAK+1)):
  - +1 when D is granted while i_req=1.
  - Cleared when I is granted, or when i_req=0.
  - Saturates at MAX_D_STREAK.
- FSM:
  - States: IDLE (no response pending) and RESP (response this cycle).
  - IDLE→RESP on a grant.
  - RESP→RESP on a grant (pipelined).
  - RESP→IDLE when there is no grant.
- Reset:
  - Forces IDLE, streak=0 and rsp_valid=0.
  - All outputs are 0 in the cycle after reset is sampled.
  - gnt is 0 while reset=1.
- Boundary and corner cases:
  - Reset during the grant cycle: the access is discarded and no rvalid is produced.
  - Reset during the RESP cycle: rvalid is still visible that cycle only if reset was low on the previous edge; after the edge it is 0.
  - A D read to the same address as the previous cycle's D write returns the new data (RAM read-after-write across cycles).
  - Address wrap: addresses are used modulo 2^ADDR_W and are not checked.
  - A req that drops without ever being granted is legal and has no effect.

Decomposition:
- Shared package holds:
  - localparams ADDR_W, DATA_W and BE_W=DATA_W/8;
  - an enum rsp_sel_e {SEL_I, SEL_D};
  - an enum for the state {IDLE, RESP}.
- One natural sub-module: mem_port_prio, the combinational priority picker with its streak counter. It outputs grant_i and grant_d.

Test Plan:
- I read alone. Stimulus: RAM[0x05]=0xDEADBEEF; i_req=1, i_addr=0x05 at cycle 0. Required: i_gnt=1, ram_en=1, ram_addr=0x05 at cycle 0; i_rvalid=1, i_rdata=0xDEADBEEF at cycle 1.
- Simultaneous requests. Stimulus: both req at cycle 0, D addr=0x02, I addr=0x07. Required: d_gnt at cycle 0, I held; i_gnt at cycle 1; d_rvalid at cycle 1; i_rvalid at cycle 2.
- D write then read. Stimulus: write d_we=0011, addr=0x10, wdata=0x12345678 over old 0xAAAAAAAA at cycle 0, then read at cycle 1. Required: ram_we=0011 at cycle 0; d_rvalid=1, d_rdata=0 at cycle 1; d_rdata=0xAAAA5678 at cycle 2.
- Starvation guard. Stimulus: MAX_D_STREAK=2, both req held for 6 cycles. Required: grant order D,D,I,D,D,I.
- Pipelined fetch. Stimulus: i_req held with i_addr 0,1,2,3 advancing on each gnt. Required: i_gnt on 4 consecutive cycles; i_rvalid on 4 consecutive cycles with RAM[0..3] in order.
- Reset mid-stream. Stimulus: D read granted at cycle 0, reset=1 at cycle 1. Required: no d_rvalid at cycle 2; all outputs 0 and streak=0 at cycle 2; a fresh request at cycle 3 completes normally.
